// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - ID/EX issue stage with MEM/WB forwarding and stall-time operand refresh
module alu_issue_stage #(
   parameter int XLEN        = 32,
   parameter int ALUOPS_SIZE = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   flush,
   input  logic                   id_valid,
   output logic                   id_ready,
   input  logic [4:0]             id_rs1,
   input  logic [4:0]             id_rs2,
   input  logic [4:0]             id_rd,
   input  logic [XLEN-1:0]        id_rs1_data,
   input  logic [XLEN-1:0]        id_rs2_data,
   input  logic [XLEN-1:0]        id_pc,
   input  logic [XLEN-1:0]        id_imm,
   input  logic                   id_srcA_sel,
   input  logic                   id_srcB_sel,
   input  logic [ALUOPS_SIZE-1:0] id_aluop,
   input  logic                   id_reg_write,
   input  logic                   mem_reg_write,
   input  logic [4:0]             mem_rd,
   input  logic [XLEN-1:0]        mem_result,
   input  logic                   wb_reg_write,
   input  logic [4:0]             wb_rd,
   input  logic [XLEN-1:0]        wb_result,
   output logic                   ex_valid,
   input  logic                   ex_ready,
   output logic [XLEN-1:0]        inputA,
   output logic [XLEN-1:0]        inputB,
   output logic [ALUOPS_SIZE-1:0] ALUop,
   output logic [4:0]             ex_rd,
   output logic                   ex_reg_write,
   output logic [XLEN-1:0]        ex_pc
);

   logic                   ex_valid_q, ex_valid_d;
   logic [4:0]             rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
   logic [XLEN-1:0]        rs1_data_q, rs1_data_d, rs2_data_q, rs2_data_d;
   logic [XLEN-1:0]        pc_q, pc_d, imm_q, imm_d;
   logic                   srca_q, srca_d, srcb_q, srcb_d;
   logic [ALUOPS_SIZE-1:0] aluop_q, aluop_d;
   logic                   reg_write_q, reg_write_d;

   logic [XLEN-1:0]        fwd_rs1, fwd_rs2;
   logic                   load;
   logic                   refresh;

   // A held instruction blocks decode only until downstream consumes it.
   assign id_ready = !ex_valid_q || ex_ready;
   assign load     = id_valid && id_ready && !flush;
   assign refresh  = ex_valid_q && !ex_ready && !flush;

   // rs1 operand: x0 reads as zero, MEM beats WB, else the held data.
   always_comb begin
      fwd_rs1 = rs1_data_q;
      if (rs1_q == 5'd0)
         fwd_rs1 = '0;
      else if (mem_reg_write && (mem_rd == rs1_q))
         fwd_rs1 = mem_result;
      else if (wb_reg_write && (wb_rd == rs1_q))
         fwd_rs1 = wb_result;
   end

   // rs2 operand: same selection rules as rs1.
   always_comb begin
      fwd_rs2 = rs2_data_q;
      if (rs2_q == 5'd0)
         fwd_rs2 = '0;
      else if (mem_reg_write && (mem_rd == rs2_q))
         fwd_rs2 = mem_result;
      else if (wb_reg_write && (wb_rd == rs2_q))
         fwd_rs2 = wb_result;
   end

   // Next state: flush beats load beats drain; a stall folds forwarded values back into the held data.
   always_comb begin
      ex_valid_d  = ex_valid_q;
      rs1_d       = rs1_q;
      rs2_d       = rs2_q;
      rd_d        = rd_q;
      rs1_data_d  = rs1_data_q;
      rs2_data_d  = rs2_data_q;
      pc_d        = pc_q;
      imm_d       = imm_q;
      srca_d      = srca_q;
      srcb_d      = srcb_q;
      aluop_d     = aluop_q;
      reg_write_d = reg_write_q;
      if (flush) begin
         ex_valid_d = 1'b0;
      end else if (load) begin
         ex_valid_d  = 1'b1;
         rs1_d       = id_rs1;
         rs2_d       = id_rs2;
         rd_d        = id_rd;
         rs1_data_d  = id_rs1_data;
         rs2_data_d  = id_rs2_data;
         pc_d        = id_pc;
         imm_d       = id_imm;
         srca_d      = id_srcA_sel;
         srcb_d      = id_srcB_sel;
         aluop_d     = id_aluop;
         reg_write_d = id_reg_write;
      end else if (ex_valid_q && ex_ready) begin
         ex_valid_d = 1'b0;
      end else if (refresh) begin
         rs1_data_d = fwd_rs1;
         rs2_data_d = fwd_rs2;
      end
   end

   // Pipeline register with synchronous reset of every field.
   always_ff @(posedge clk) begin
      if (rst) begin
         ex_valid_q  <= 1'b0;
         rs1_q       <= '0;
         rs2_q       <= '0;
         rd_q        <= '0;
         rs1_data_q  <= '0;
         rs2_data_q  <= '0;
         pc_q        <= '0;
         imm_q       <= '0;
         srca_q      <= 1'b0;
         srcb_q      <= 1'b0;
         aluop_q     <= '0;
         reg_write_q <= 1'b0;
      end else begin
         ex_valid_q  <= ex_valid_d;
         rs1_q       <= rs1_d;
         rs2_q       <= rs2_d;
         rd_q        <= rd_d;
         rs1_data_q  <= rs1_data_d;
         rs2_data_q  <= rs2_data_d;
         pc_q        <= pc_d;
         imm_q       <= imm_d;
         srca_q      <= srca_d;
         srcb_q      <= srcb_d;
         aluop_q     <= aluop_d;
         reg_write_q <= reg_write_d;
      end
   end

   assign ex_valid     = ex_valid_q;
   assign inputA       = srca_q ? pc_q : fwd_rs1;
   assign inputB       = srcb_q ? imm_q : fwd_rs2;
   assign ALUop        = aluop_q;
   assign ex_rd        = rd_q;
   assign ex_reg_write = reg_write_q;
   assign ex_pc        = pc_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb/tb_alu_issue_stage.sv - scoreboard bench for alu_issue_stage
module tb_alu_issue_stage;

   logic        clk, rst, flush;
   logic        id_valid, id_ready;
   logic [4:0]  id_rs1, id_rs2, id_rd;
   logic [31:0] id_rs1_data, id_rs2_data, id_pc, id_imm;
   logic        id_srcA_sel, id_srcB_sel;
   logic [3:0]  id_aluop;
   logic        id_reg_write;
   logic        mem_reg_write, wb_reg_write;
   logic [4:0]  mem_rd, wb_rd;
   logic [31:0] mem_result, wb_result;
   logic        ex_valid, ex_ready;
   logic [31:0] inputA, inputB, ex_pc;
   logic [3:0]  ALUop;
   logic [4:0]  ex_rd;
   logic        ex_reg_write;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [4:0]  rs1, rs2, rd;
      logic [31:0] d1, d2, pc, imm;
      logic        sa, sb, rw;
      logic [3:0]  op;
   } rec_t;

   rec_t exp_q[$];

   alu_issue_stage #(.XLEN(32), .ALUOPS_SIZE(4)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .id_valid(id_valid), .id_ready(id_ready),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
      .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
      .id_pc(id_pc), .id_imm(id_imm),
      .id_srcA_sel(id_srcA_sel), .id_srcB_sel(id_srcB_sel),
      .id_aluop(id_aluop), .id_reg_write(id_reg_write),
      .mem_reg_write(mem_reg_write), .mem_rd(mem_rd), .mem_result(mem_result),
      .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_result(wb_result),
      .ex_valid(ex_valid), .ex_ready(ex_ready),
      .inputA(inputA), .inputB(inputB), .ALUop(ALUop),
      .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_pc(ex_pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
      end
   endtask

   // Freshest architectural value of a source register as seen by the consumer.
   function automatic logic [31:0] operand(input logic [4:0] rs, input logic [31:0] held);
      if (rs == 5'd0) return 32'd0;
      if (mem_reg_write && mem_rd == rs) return mem_result;
      if (wb_reg_write && wb_rd == rs) return wb_result;
      return held;
   endfunction

   // Issue tracker: records accepted instructions, retires consumed ones, discards on flush/reset.
   always @(posedge clk) begin
      if (rst || flush) begin
         exp_q.delete();
      end else begin
         logic acc;
         rec_t r;
         acc = id_valid && (exp_q.size() == 0 || ex_ready);
         if (exp_q.size() != 0) begin
            if (ex_ready) void'(exp_q.pop_front());
            else begin
               exp_q[0].d1 = operand(exp_q[0].rs1, exp_q[0].d1);
               exp_q[0].d2 = operand(exp_q[0].rs2, exp_q[0].d2);
            end
         end
         if (acc) begin
            r.rs1 = id_rs1; r.rs2 = id_rs2; r.rd = id_rd;
            r.d1 = id_rs1_data; r.d2 = id_rs2_data; r.pc = id_pc; r.imm = id_imm;
            r.sa = id_srcA_sel; r.sb = id_srcB_sel; r.rw = id_reg_write; r.op = id_aluop;
            exp_q.push_back(r);
         end
      end
   end

   // Monitor: compares what the DUT presents against the head of the scoreboard.
   always @(negedge clk) begin
      if (!rst) begin
         chk("mon_ex_valid", ex_valid, exp_q.size() != 0);
         chk("mon_id_ready", id_ready, exp_q.size() == 0 || ex_ready);
         if (exp_q.size() != 0) begin
            chk("mon_inputA", inputA, exp_q[0].sa ? exp_q[0].pc : operand(exp_q[0].rs1, exp_q[0].d1));
            chk("mon_inputB", inputB, exp_q[0].sb ? exp_q[0].imm : operand(exp_q[0].rs2, exp_q[0].d2));
            chk("mon_ALUop", ALUop, exp_q[0].op);
            chk("mon_ex_rd", ex_rd, exp_q[0].rd);
            chk("mon_ex_reg_write", ex_reg_write, exp_q[0].rw);
            chk("mon_ex_pc", ex_pc, exp_q[0].pc);
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic offer(input logic [4:0] rs1, input logic [31:0] d1, input logic [4:0] rs2,
                        input logic [31:0] d2, input logic [31:0] pc, input logic [31:0] imm,
                        input logic sa, input logic sb, input logic [3:0] op);
      id_valid = 1'b1;
      id_rs1 = rs1; id_rs1_data = d1; id_rs2 = rs2; id_rs2_data = d2;
      id_pc = pc; id_imm = imm; id_srcA_sel = sa; id_srcB_sel = sb;
      id_aluop = op; id_rd = 5'd9; id_reg_write = 1'b1;
   endtask

   logic [31:0] pc_cnt;

   initial begin
      rst = 1'b1; flush = 1'b0; ex_ready = 1'b1;
      mem_reg_write = 1'b0; mem_rd = 5'd0; mem_result = 32'd0;
      wb_reg_write = 1'b0; wb_rd = 5'd0; wb_result = 32'd0;
      offer(5'd5, 32'd10, 5'd6, 32'd0, 32'h40, 32'hFFFF_FFFC, 1'b0, 1'b1, 4'h3);

      // Reset held for two edges with an instruction offered.
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ex_valid", ex_valid, 32'd0);
      chk("rst_inputA", inputA, 32'd0);
      chk("rst_inputB", inputB, 32'd0);
      chk("rst_ALUop", ALUop, 32'd0);
      rst = 1'b0;
      #1;
      chk("rst_id_ready", id_ready, 32'd1);

      // Basic accept: rs1 register operand, immediate on B.
      cyc();
      chk("basic_ex_valid", ex_valid, 32'd1);
      chk("basic_inputA", inputA, 32'd10);
      chk("basic_inputB", inputB, 32'hFFFF_FFFC);
      chk("basic_ALUop", ALUop, 32'd3);

      // Forwarding priority on a stalled instruction with rs1=x7.
      offer(5'd7, 32'h33, 5'd0, 32'd0, 32'h44, 32'd0, 1'b0, 1'b1, 4'h1);
      cyc();
      id_valid = 1'b0; ex_ready = 1'b0;
      mem_reg_write = 1'b1; mem_rd = 5'd7; mem_result = 32'h11;
      wb_reg_write = 1'b1; wb_rd = 5'd7; wb_result = 32'h22;
      #1;
      chk("prio_mem_over_wb", inputA, 32'h11);
      mem_rd = 5'd0;
      #1;
      chk("prio_wb_only", inputA, 32'h22);
      cyc();
      mem_reg_write = 1'b0; wb_reg_write = 1'b0;
      #1;
      chk("prio_sticky_after_drop", inputA, 32'h22);

      // x0 source: never forwarded, held data ignored.
      ex_ready = 1'b1;
      offer(5'd0, 32'h99, 5'd0, 32'd0, 32'h48, 32'd0, 1'b0, 1'b1, 4'h2);
      mem_reg_write = 1'b1; mem_rd = 5'd0; mem_result = 32'h77;
      cyc();
      chk("x0_ex_valid", ex_valid, 32'd1);
      chk("x0_inputA", inputA, 32'd0);
      id_valid = 1'b0; mem_reg_write = 1'b0;

      // Sticky stall: WB pulse for x3 must persist while stalled.
      offer(5'd0, 32'd0, 5'd3, 32'd1, 32'h4C, 32'd0, 1'b0, 1'b0, 4'h4);
      cyc();
      ex_ready = 1'b0;
      offer(5'd1, 32'd5, 5'd2, 32'd6, 32'h50, 32'd0, 1'b0, 1'b0, 4'h5);
      wb_reg_write = 1'b1; wb_rd = 5'd3; wb_result = 32'h55;
      #1;
      chk("sticky_inputB_c0", inputB, 32'h55);
      chk("sticky_id_ready_c0", id_ready, 32'd0);
      cyc();
      wb_reg_write = 1'b0;
      #1;
      chk("sticky_inputB_c1", inputB, 32'h55);
      chk("sticky_id_ready_c1", id_ready, 32'd0);
      cyc();
      chk("sticky_inputB_c2", inputB, 32'h55);
      chk("sticky_ex_valid_c2", ex_valid, 32'd1);

      // Flush kills the held instruction and the one offered alongside.
      flush = 1'b1; ex_ready = 1'b1;
      offer(5'd1, 32'd5, 5'd2, 32'd6, 32'h54, 32'd0, 1'b0, 1'b0, 4'h6);
      cyc();
      flush = 1'b0; id_valid = 1'b0;
      #1;
      chk("flush_ex_valid", ex_valid, 32'd0);
      cyc();
      chk("flush_not_presented", ex_valid, 32'd0);

      // Streaming: four back-to-back instructions, no bubbles.
      for (int i = 0; i < 4; i++) begin
         offer(5'd1, 32'd0, 5'd2, 32'd0, 32'h1000 + 32'(i * 4), 32'd0, 1'b1, 1'b1, 4'(i));
         cyc();
         chk("stream_ex_valid", ex_valid, 32'd1);
         chk("stream_inputA", inputA, 32'h1000 + 32'(i * 4));
      end
      id_valid = 1'b0;
      cyc();
      chk("stream_drained", ex_valid, 32'd0);

      // Randomized traffic checked by the scoreboard monitor.
      pc_cnt = 32'h2000;
      for (int c = 0; c < 3000; c++) begin
         id_valid      = ($urandom_range(0, 3) != 0);
         id_rs1        = 5'($urandom_range(0, 7));
         id_rs2        = 5'($urandom_range(0, 7));
         id_rd         = 5'($urandom_range(0, 31));
         id_rs1_data   = $urandom;
         id_rs2_data   = $urandom;
         id_pc         = pc_cnt;
         pc_cnt        = pc_cnt + 32'd4;
         id_imm        = $urandom;
         id_srcA_sel   = 1'($urandom_range(0, 1));
         id_srcB_sel   = 1'($urandom_range(0, 1));
         id_aluop      = 4'($urandom_range(0, 15));
         id_reg_write  = 1'($urandom_range(0, 1));
         mem_reg_write = 1'($urandom_range(0, 1));
         mem_rd        = 5'($urandom_range(0, 7));
         mem_result    = $urandom;
         wb_reg_write  = 1'($urandom_range(0, 1));
         wb_rd         = 5'($urandom_range(0, 7));
         wb_result     = $urandom;
         ex_ready      = ($urandom_range(0, 3) != 0);
         flush         = ($urandom_range(0, 19) == 0);
         rst           = ($urandom_range(0, 249) == 0);
         cyc();
      end

      rst = 1'b0; flush = 1'b0; id_valid = 1'b0; ex_ready = 1'b1;
      mem_reg_write = 1'b0; wb_reg_write = 1'b0;
      repeat (3) cyc();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

ID/EX pipeline stage of the rv32if core that sits directly upstream of the integer ALU. It captures decoded operands from decode under a valid/ready handshake and selects register, PC or immediate sources. It resolves RAW hazards by forwarding from MEM and WB, and presents `inputA`, `inputB` and `ALUop` to the ALU. Operands held during a downstream stall are kept current, so a stalled instruction never sees stale data after the producer retires.

## Interface
- `XLEN`, default 32 (from `` `XLEN ``): datapath width.
- `ALUOPS_SIZE`, default 4 (from `` `ALUOPS_SIZE ``): ALU opcode width.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `flush`  in  1  kill the held instruction and any instruction offered this cycle.
- `id_valid`  in  1  decode offers an instruction.
- `id_ready`  out  1  stage accepts this cycle.
- `id_rs1`, `id_rs2`, `id_rd`  in  5 each  register indices.
- `id_rs1_data`, `id_rs2_data`  in  XLEN each  register-file read data.
- `id_pc`, `id_imm`  in  XLEN each  instruction PC, sign-extended immediate.
- `id_srcA_sel`  in  1  0 = rs1, 1 = PC.
- `id_srcB_sel`  in  1  0 = rs2, 1 = imm.
- `id_aluop`  in  ALUOPS_SIZE  ALU operation.
- `id_reg_write`  in  1  instruction writes `rd`.
- `mem_reg_write`, `mem_rd`, `mem_result`  in  1/5/XLEN  MEM-stage producer.
- `wb_reg_write`, `wb_rd`, `wb_result`  in  1/5/XLEN  WB-stage producer.
- `ex_valid`  out  1  held instruction valid.
- `ex_ready`  in  1  downstream consumes this cycle.
- `inputA`, `inputB`  out  XLEN each  ALU operands.
- `ALUop`  out  ALUOPS_SIZE  ALU operation.
- `ex_rd`, `ex_reg_write`, `ex_pc`  out  5/1/XLEN  sideband carried forward.

## Operation
- Registered state: `ex_valid`, rs1/rs2 indices, rs1/rs2 data, pc, imm, srcA/srcB selects, aluop, rd, reg_write.
- `id_ready = !ex_valid || ex_ready` (combinational; independent of `flush`).
- Load happens when `id_valid && id_ready && !flush`: all fields are captured and `ex_valid` is set to 1.
- Drain happens when `ex_valid && ex_ready` with no load: `ex_valid` is set to 0.
- Flush clears `ex_valid` next cycle. It has priority over load and drain, and an instruction offered in the same cycle is discarded.
- Forwarding applies per source reg `rsN` and is combinational on the held index:
  - MEM hit: `mem_reg_write && mem_rd == rsN && rsN != 0`.
  - WB hit: the same test on the WB inputs.
  - MEM has priority over WB; otherwise the held data is used.
  - x0 is never forwarded, and a held x0 value is 0 regardless of the captured data.
- Operand mux: `inputA = srcA_sel ? pc : fwd_rs1`, `inputB = srcB_sel ? imm : fwd_rs2`.
- Sticky refresh: while `ex_valid && !ex_ready && !flush`, the rs1/rs2 data registers are rewritten with their forwarded values every cycle. Other fields hold.
- Outputs are driven from registers or the forwarding mux. While `!ex_valid`, the outputs hold their last values and are don't-care to consumers.
- Load-use detection belongs to decode and is outside this block.

## Timing
- Reset, synchronous and checked first: every output register and `ex_valid` goes to 0. After reset `ALUop` = 0, `inputA`/`inputB` = 0 (selects 0, data 0, no forwarding hit), and `id_ready` = 1.
- Latency: an instruction accepted at edge N is visible on `ex_valid`/`inputA`/`inputB` immediately after edge N.
- Throughput: one instruction per cycle when `ex_ready` is held at 1.
- Back-to-back: load and drain in the same cycle replace the held instruction, and `ex_valid` stays 1.
- Forwarding adds no cycle; producer changes propagate to `inputA`/`inputB` in the same cycle.
- Reset or flush mid-stall: the held instruction is discarded with no partial output. The next accept starts clean.

## Test plan
- Reset: assert `rst` 2 cycles with `id_valid`=1 -> `ex_valid`=0, `inputA`=`inputB`=0, `ALUop`=0; one cycle after release `id_ready`=1 and the instruction is accepted.
- Basic: rs1=5 (data 10), imm=0xFFFFFFFC, srcB_sel=1, aluop=ADD, `ex_ready`=1 -> next cycle `inputA`=10, `inputB`=0xFFFFFFFC, `ex_valid`=1.
- Priority: held rs1=7, MEM writes x7=0x11, WB writes x7=0x22 -> `inputA`=0x11. With `mem_rd`=0 and rs1=0 -> `inputA`=0 (held data 0x99 ignored).
- Sticky stall: `ex_ready`=0, held rs2=3 (stale 1), WB writes x3=0x55 for one cycle then drops -> `inputB`=0x55 in that cycle and every later stalled cycle. `id_ready`=0 throughout.
- Flush: `flush`=1 with `id_valid`=1 and `ex_valid`=1 -> next cycle `ex_valid`=0 and the offered instruction is never presented.
- Streaming: 4 instructions with `id_valid`=`ex_ready`=1 -> `ex_valid` stays 1 for 4 consecutive cycles, in order, with no bubbles.
